// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path: the FSM state encoding used
//   by uart_tx_arbiter, the default maximum message length, the width of the
//   grant index, and a few ASCII constants used by message sources.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Encoding is fixed so that a state probe reads the same in every build.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // Longest message a source can post, in bytes.
  localparam int MAX_BYTES = 8;

  // Width of a source index; covers the largest supported NUM_REQ of 8.
  localparam int GRANT_W = 3;

  localparam logic [7:0] CHAR_LF = 8'h0a;
  localparam logic [7:0] CHAR_0  = 8'h30;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin select. Starting at index ptr and
//   wrapping modulo NUM_REQ, the first asserted request wins. The pointer
//   register lives in the caller so that it only moves when a grant is taken.
//
// Ports
//   req        in   NUM_REQ   pending requests
//   ptr        in   3         highest-priority index this cycle (< NUM_REQ)
//   grant      out  NUM_REQ   one-hot winner, all zero when req == 0
//   grant_idx  out  3         binary index of the winner, 0 when req == 0
//   valid      out  1         at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GRANT_W-1:0] grant_idx,
  output logic               valid
);

  // Scan priority slots k = 0..NUM_REQ-1; slot k maps to source (ptr+k) mod
  // NUM_REQ. The inner loop keeps every index a loop constant, so the result
  // is a plain priority mux with no variable bit-selects.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path through the block leaves a value unassigned (no latches).
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_REQ))) begin
          valid     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = GRANT_W'(i);
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares the single UART tx FIFO write port between NUM_REQ message
//   sources. In IDLE one pending source is chosen round-robin and its whole
//   message is latched; the source is released with ack while the latched
//   copy is streamed byte by byte into the FIFO, honouring tx_fifo_full.
//   Flow: IDLE -> LOAD (ack) -> SEND (bytes) -> DONE (done) -> IDLE.
//
// Ports
//   clk            in   1                    system clock
//   rst            in   1                    synchronous, active-high reset
//   req            in   NUM_REQ              source i has a message pending
//   req_len        in   NUM_REQ*LEN_W        length of message i, bytes
//   req_msg        in   NUM_REQ*MAX_BYTES*8  message i, byte 0 sent first
//   ack            out  NUM_REQ              pulse: message i latched
//   done           out  NUM_REQ              pulse: last byte of i written
//   busy           out  1                    high outside IDLE
//   grant_id       out  3                    source currently served
//   tx_fifo_full   in   1                    tx FIFO full flag
//   tx_fifo_wr_en  out  1                    tx FIFO write strobe
//   tx_fifo_din    out  8                    tx FIFO write data
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BYTES = uart_pkg::MAX_BYTES,
  parameter int LEN_W     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*LEN_W-1:0]         req_len,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0]   req_msg,
  output logic [NUM_REQ-1:0]               ack,
  output logic [NUM_REQ-1:0]               done,
  output logic                             busy,
  output logic [uart_pkg::GRANT_W-1:0]     grant_id,
  input  logic                             tx_fifo_full,
  output logic                             tx_fifo_wr_en,
  output logic [7:0]                       tx_fifo_din
);

  import uart_pkg::*;

  localparam int                 MSG_W    = MAX_BYTES * 8;
  localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUM_REQ - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_BYTES);

  state_t             state_q;
  state_t             state_d;
  logic [GRANT_W-1:0] ptr_q;

  logic [NUM_REQ-1:0] win_grant;
  logic [GRANT_W-1:0] win_idx;
  logic               win_valid;
  logic               take;

  logic [LEN_W-1:0]   sel_len;
  logic [LEN_W-1:0]   clamped_len;
  logic [MSG_W-1:0]   sel_msg;

  logic [MSG_W-1:0]   msg_q;
  logic [LEN_W-1:0]   eff_len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [7:0]         byte_sel;
  logic               last_byte;

  // -------------------------------------------------------------------------
  // Winner select
  // -------------------------------------------------------------------------
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  // A grant is taken only from IDLE; requests arriving later simply wait.
  assign take = (state_q == IDLE) && win_valid;

  // One-hot AND-OR mux of the winner's length and message: avoids indexing
  // the wide request buses with a variable offset.
  always_comb begin
    sel_len = '0;
    sel_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        sel_len = sel_len | req_len[i*LEN_W +: LEN_W];
        sel_msg = sel_msg | req_msg[i*MSG_W +: MSG_W];
      end
    end
  end

  // Oversized lengths are clamped rather than flagged.
  assign clamped_len = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;

  // -------------------------------------------------------------------------
  // FSM: state register, grant index and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before this clock edge.
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_id <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_id <= win_idx;
        ptr_q    <= (win_idx == LAST_IDX) ? '0 : win_idx + GRANT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Message latch and byte counter
  // -------------------------------------------------------------------------
  // NOTE: the message store, length and counter carry no reset: each is
  // written in IDLE/LOAD before it is ever read, and every output derived
  // from them is gated by the (reset) state.
  always_ff @(posedge clk) begin
    if (take) begin
      msg_q     <= sel_msg;
      eff_len_q <= clamped_len;
    end
    if (state_q == LOAD) begin
      cnt_q <= '0;
    end else if (tx_fifo_wr_en) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  // Current byte; cnt_q < eff_len_q <= MAX_BYTES whenever it is used.
  always_comb begin
    byte_sel = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (cnt_q == LEN_W'(b)) begin
        byte_sel = msg_q[b*8 +: 8];
      end
    end
  end

  // Only meaningful in SEND, where eff_len_q is at least 1.
  assign last_byte = (cnt_q == eff_len_q - LEN_W'(1));

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (win_valid) state_d = LOAD;
      LOAD: state_d = (eff_len_q == '0) ? DONE : SEND;
      SEND: if (tx_fifo_wr_en && last_byte) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  // The write strobe follows tx_fifo_full combinationally so a byte is
  // offered every cycle the FIFO can take it, and never otherwise.
  always_comb begin
    ack           = '0;
    done          = '0;
    busy          = (state_q != IDLE);
    tx_fifo_wr_en = 1'b0;
    tx_fifo_din   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i]  = (state_q == LOAD) && (grant_id == GRANT_W'(i));
      done[i] = (state_q == DONE) && (grant_id == GRANT_W'(i));
    end
    if (state_q == SEND) begin
      tx_fifo_wr_en = !tx_fifo_full;
      tx_fifo_din   = byte_sel;
    end
  end

endmodule : uart_tx_arbiter
